// File: rtl/mag_power_control_if.sv
// Front-panel, door and timer inputs plus magnetron/timer outputs
// of the microwave power controller.
interface mag_power_control_if #(
    parameter int LW = 4
);
    logic          Nstart;
    logic          Nstop;
    logic          Nclear;
    logic          door_clo;
    logic          time_over;
    logic [LW-1:0] power;
    logic          mag_on;
    logic          cooking;
    logic          paused;
    logic          done;
    logic [1:0]    state;

    modport master (
        output Nstart, Nstop, Nclear, door_clo, time_over, power,
        input  mag_on, cooking, paused, done, state
    );

    modport slave (
        input  Nstart, Nstop, Nclear, door_clo, time_over, power,
        output mag_on, cooking, paused, done, state
    );
endinterface

// File: rtl/mag_power_control.sv
// Magnetron on/off state machine with pause/resume, timed done
// state and duty-cycled power level.
module mag_power_control #(
    parameter int LEVELS      = 10,
    parameter int SLOT        = 4,
    parameter int DONE_CYCLES = 8,
    parameter int LW          = $clog2(LEVELS + 1)
) (
    input  logic                 clk,
    input  logic                 Nreset,
    mag_power_control_if.slave   bus
);
    localparam int F   = LEVELS * SLOT;
    localparam int PW  = (F > 1) ? $clog2(F) : 1;
    localparam int PW1 = PW + 1;
    localparam int CW  = $clog2(DONE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COOK   = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [LW-1:0] p_q, p_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          nstart_d_q;
    logic          cooking_q, paused_q, done_q;

    logic          start_ok;
    logic [LW-1:0] p_clamp;
    logic [PW1-1:0] thr;

    always_comb begin
        start_ok = nstart_d_q & ~bus.Nstart & bus.door_clo & ~bus.time_over;
        if (bus.power == '0)
            p_clamp = LW'(1);
        else if (bus.power > LW'(LEVELS))
            p_clamp = LW'(LEVELS);
        else
            p_clamp = bus.power;
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        ph_d    = ph_q;
        dcnt_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = COOK;
                    p_d     = p_clamp;
                end
            end
            COOK: begin
                if (!bus.Nclear)
                    state_d = IDLE;
                else if (bus.time_over)
                    state_d = DONE;
                else if (!bus.door_clo || !bus.Nstop)
                    state_d = PAUSED;
                else
                    ph_d = (ph_q == PW'(F - 1)) ? '0 : ph_q + 1'b1;
            end
            PAUSED: begin
                if (!bus.Nclear || !bus.Nstop) begin
                    state_d = IDLE;
                end else if (start_ok) begin
                    state_d = COOK;
                    p_d     = p_clamp;
                end
            end
            DONE: begin
                if (!bus.Nclear || !bus.Nstop)
                    state_d = IDLE;
                else if (dcnt_q == CW'(DONE_CYCLES - 1))
                    state_d = IDLE;
                else
                    dcnt_d = dcnt_q + 1'b1;
            end
        endcase
        // every (re)entry into COOK restarts the duty frame with the drive on
        if (state_d == COOK && state_q != COOK)
            ph_d = '0;
    end

    always_ff @(posedge clk or negedge Nreset) begin
        if (!Nreset) begin
            state_q    <= IDLE;
            ph_q       <= '0;
            p_q        <= LW'(1);
            dcnt_q     <= '0;
            nstart_d_q <= 1'b1;
            cooking_q  <= 1'b0;
            paused_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            p_q        <= p_d;
            dcnt_q     <= dcnt_d;
            nstart_d_q <= bus.Nstart;
            cooking_q  <= (state_d == COOK);
            paused_q   <= (state_d == PAUSED);
            done_q     <= (state_d == DONE);
        end
    end

    assign thr = PW1'(p_q) * PW1'(SLOT);

    // door gate is deliberately combinational: opening the door kills the drive at once
    assign bus.mag_on  = (state_q == COOK) & ({1'b0, ph_q} < thr) & bus.door_clo;
    assign bus.cooking = cooking_q;
    assign bus.paused  = paused_q;
    assign bus.done    = done_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_mag_power_control.sv
// Self-checking bench: cycle-accurate behavioural model plus directed
// scenarios with hand-computed expectations and a random phase.
module tb_mag_power_control;
    localparam int LEVELS = 10;
    localparam int SLOT   = 4;
    localparam int F      = LEVELS * SLOT;
    localparam int DONE_N = 8;

    logic clk;
    logic Nreset;
    int   n_assert;
    int   n_fail;
    bit   run_cmp;

    mag_power_control_if #(.LW(4)) bus ();

    mag_power_control #(
        .LEVELS(LEVELS), .SLOT(SLOT), .DONE_CYCLES(DONE_N), .LW(4)
    ) dut (
        .clk(clk),
        .Nreset(Nreset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: state 0..3, cycles since COOK entry, latched power, cycles in DONE
    int m_st;
    int m_t;
    int m_p;
    int m_dn;
    bit m_prev;

    function automatic int clampp(int pw);
        if (pw == 0) return 1;
        if (pw > LEVELS) return LEVELS;
        return pw;
    endfunction

    task automatic model_reset();
        m_st   = 0;
        m_t    = 0;
        m_p    = 1;
        m_dn   = 0;
        m_prev = 1'b1;
    endtask

    task automatic model_step();
        bit acc;
        acc = m_prev && !bus.Nstart && bus.door_clo && !bus.time_over;
        case (m_st)
            0: if (acc) begin
                m_st = 1; m_t = 0; m_p = clampp(int'(bus.power));
            end
            1: begin
                if (!bus.Nclear) m_st = 0;
                else if (bus.time_over) begin m_st = 3; m_dn = 0; end
                else if (!bus.door_clo || !bus.Nstop) m_st = 2;
                else m_t++;
            end
            2: begin
                if (!bus.Nclear || !bus.Nstop) m_st = 0;
                else if (acc) begin
                    m_st = 1; m_t = 0; m_p = clampp(int'(bus.power));
                end
            end
            default: begin
                if (!bus.Nclear || !bus.Nstop) m_st = 0;
                else begin
                    m_dn++;
                    if (m_dn == DONE_N) m_st = 0;
                end
            end
        endcase
        m_prev = bus.Nstart;
    endtask

    initial forever begin
        @(posedge clk);
        if (!Nreset) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge Nreset);
        model_reset();
    end

    task automatic chk(string name, int act, int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (run_cmp) begin
            bit em;
            em = (m_st == 1) && ((m_t % F) < m_p * SLOT) && bus.door_clo && Nreset;
            chk("cmp_mag_on",  int'(bus.mag_on),  int'(em));
            chk("cmp_cooking", int'(bus.cooking), int'(m_st == 1));
            chk("cmp_paused",  int'(bus.paused),  int'(m_st == 2));
            chk("cmp_done",    int'(bus.done),    int'(m_st == 3));
            chk("cmp_state",   int'(bus.state),   m_st);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        bus.Nstart = 1'b0;
        tick();
        bus.Nstart = 1'b1;
    endtask

    task automatic to_idle();
        bus.Nclear = 1'b0;
        tick();
        bus.Nclear = 1'b1;
        tick();
    endtask

    // start, then count drive-on cycles over one full frame
    task automatic duty_frame(output int ones);
        ones = 0;
        pulse_start();
        for (int i = 0; i < F; i++) begin
            #1;
            if (bus.mag_on) ones++;
            tick();
        end
    endtask

    initial begin
        int cnt_on;
        int cnt_done;
        n_assert = 0;
        n_fail   = 0;
        run_cmp  = 1'b0;
        model_reset();
        bus.Nstart    = 1'b1;
        bus.Nstop     = 1'b1;
        bus.Nclear    = 1'b1;
        bus.door_clo  = 1'b1;
        bus.time_over = 1'b0;
        bus.power     = 4'd3;
        Nreset        = 1'b1;
        #1 Nreset     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mag_on",  int'(bus.mag_on),  0);
        chk("rst_cooking", int'(bus.cooking), 0);
        chk("rst_paused",  int'(bus.paused),  0);
        chk("rst_done",    int'(bus.done),    0);
        chk("rst_state",   int'(bus.state),   0);
        #1 Nreset = 1'b1;
        run_cmp = 1'b1;
        tick();

        // 1: duty 12/40 at power 3, then timed DONE
        duty_frame(cnt_on);
        chk("duty_p3", cnt_on, 12);
        bus.time_over = 1'b1;
        tick();
        cnt_done = 0;
        cnt_on   = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (bus.done) cnt_done++;
            if (bus.mag_on) cnt_on++;
            tick();
        end
        chk("done_len", cnt_done, 8);
        chk("done_mag", cnt_on, 0);
        chk("done_to_idle", int'(bus.state), 0);
        bus.time_over = 1'b0;
        tick();

        // 2: door opens mid-cook, resume restarts frame
        bus.power = 4'd10;
        pulse_start();
        repeat (4) tick();
        bus.door_clo = 1'b0;
        #1;
        chk("door_mag_now", int'(bus.mag_on), 0);
        chk("door_state_now", int'(bus.state), 1);
        tick();
        chk("door_paused", int'(bus.state), 2);
        bus.door_clo = 1'b1;
        pulse_start();
        #1;
        chk("resume_state", int'(bus.state), 1);
        chk("resume_mag", int'(bus.mag_on), 1);

        // 3: stop, stop, clear
        bus.Nstop = 1'b0;
        tick();
        bus.Nstop = 1'b1;
        chk("stop_paused", int'(bus.state), 2);
        bus.Nstop = 1'b0;
        tick();
        bus.Nstop = 1'b1;
        chk("stop_idle", int'(bus.state), 0);
        pulse_start();
        tick();
        bus.Nclear = 1'b0;
        tick();
        bus.Nclear = 1'b1;
        chk("clear_idle", int'(bus.state), 0);

        // 4: rejected and held starts
        bus.door_clo = 1'b0;
        pulse_start();
        chk("rej_door", int'(bus.state), 0);
        bus.door_clo  = 1'b1;
        bus.time_over = 1'b1;
        pulse_start();
        chk("rej_timer", int'(bus.state), 0);
        bus.time_over = 1'b0;
        tick();
        bus.Nstart = 1'b0;
        repeat (20) tick();
        chk("held_cook", int'(bus.state), 1);
        bus.Nstop = 1'b0;
        tick();
        bus.Nstop = 1'b1;
        repeat (3) tick();
        chk("held_no_retrig", int'(bus.state), 2);
        bus.Nstart = 1'b1;
        to_idle();

        // 5: simultaneous events and clamping
        pulse_start();
        tick();
        bus.time_over = 1'b1;
        bus.door_clo  = 1'b0;
        tick();
        chk("to_over_door", int'(bus.state), 3);
        bus.time_over = 1'b0;
        bus.door_clo  = 1'b1;
        to_idle();
        pulse_start();
        bus.time_over = 1'b1;
        bus.Nclear    = 1'b0;
        tick();
        chk("clear_over_to", int'(bus.state), 0);
        bus.time_over = 1'b0;
        bus.Nclear    = 1'b1;
        tick();
        bus.power = 4'd0;
        duty_frame(cnt_on);
        chk("duty_p0", cnt_on, 4);
        to_idle();
        bus.power = 4'd15;
        duty_frame(cnt_on);
        chk("duty_p15", cnt_on, 40);
        to_idle();

        // 6: async reset between edges
        bus.power = 4'd5;
        pulse_start();
        repeat (3) tick();
        Nreset = 1'b0;
        #1;
        chk("arst_mag", int'(bus.mag_on), 0);
        chk("arst_cook", int'(bus.cooking), 0);
        chk("arst_state", int'(bus.state), 0);
        tick();
        Nreset = 1'b1;
        tick();
        chk("arst_idle", int'(bus.state), 0);

        // random phase against the model
        for (int i = 0; i < 3000; i++) begin
            bus.Nstart    = ($urandom_range(0, 3) != 0);
            bus.door_clo  = ($urandom_range(0, 15) != 0);
            bus.time_over = ($urandom_range(0, 39) == 0);
            bus.Nstop     = ($urandom_range(0, 29) != 0);
            bus.Nclear    = ($urandom_range(0, 49) != 0);
            bus.power     = 4'($urandom_range(0, 15));
            tick();
        end

        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mag_power_control.md
# mag_power_control

Parametrised magnetron on/off controller for the microwave Mag_Control level, succeeding the combinational set/reset start/stop logic with a clocked state machine. It adds pause/resume, a timed "done" state, and a selectable power level implemented as a duty cycle on the magnetron drive. It sits between the debounced front-panel buttons, the door sensor and the cook timer on one side, and the magnetron drive and timer enable on the other.

## Interface
- `LEVELS`, 10: number of power levels; a duty frame has `LEVELS` slots.
- `SLOT`, 4: clock cycles per duty slot; frame length F = `LEVELS`*`SLOT` cycles.
- `DONE_CYCLES`, 8: cycles spent in DONE before returning to IDLE.
- `LW`, `$clog2(LEVELS+1)`: width of `power`.
- `clk`  in  1  single system clock, all state on rising edge.
- `Nreset`  in  1  asynchronous, active-low reset.
- `Nstart`  in  1  start/resume button, active low, synchronous, debounced upstream.
- `Nstop`  in  1  stop button, active low.
- `Nclear`  in  1  clear button, active low.
- `door_clo`  in  1  1 = door closed.
- `time_over`  in  1  1 = cook timer at zero.
- `power`  in  LW  requested power level, 1..LEVELS.
- `mag_on`  out  1  magnetron drive.
- `cooking`  out  1  timer count enable; 1 exactly while state = COOK.
- `paused`  out  1  1 while state = PAUSED.
- `done`  out  1  1 while state = DONE (beeper).
- `state`  out  2  IDLE=0, COOK=1, PAUSED=2, DONE=3.

## Operation
- Start event = falling edge of `Nstart`: registered `Nstart_d`=1 and `Nstart`=0 at a clock edge. Holding `Nstart` low produces one event only.
- Start is accepted only if `door_clo`=1 and `time_over`=0; otherwise ignored.
- On an accepted start, `power` is latched as P: 0 is clamped to 1, values above `LEVELS` are clamped to `LEVELS`. `power` changes during COOK are ignored.
- IDLE: accepted start -> COOK.
- COOK, in priority order: `Nclear`=0 -> IDLE; `time_over`=1 -> DONE; `door_clo`=0 or `Nstop`=0 -> PAUSED; otherwise stay.
- PAUSED: `Nclear`=0 or `Nstop`=0 -> IDLE; accepted start -> COOK, with P re-latched; otherwise stay. `time_over`=1 alone does not leave PAUSED.
- DONE: `Nclear`=0 or `Nstop`=0 -> IDLE immediately; otherwise -> IDLE after `DONE_CYCLES` cycles. Start events are ignored.
- Duty phase counter `ph`, 0..F-1:
  - Cleared to 0 on every entry into COOK.
  - Increments each COOK cycle and wraps F-1 -> 0.
  - Frozen in all other states.
- `mag_on` = (state==COOK) & (`ph` < P*`SLOT`) & `door_clo`. The `door_clo` gate is the only input-to-output combinational path and is a safety interlock. All other outputs decode registers only.
- P = `LEVELS` gives `mag_on` continuously high during COOK.

## Timing
- Reset state (async, while `Nreset`=0 and until the next edge after release): state=IDLE, `ph`=0, P=1, `Nstart_d`=1, done counter=0. Outputs: `mag_on`=0, `cooking`=0, `paused`=0, `done`=0, `state`=0.
- Because `Nstart_d` resets to 1, an `Nstart` held low through reset release produces one start event at the first edge.
- A start event sampled at edge k gives state=COOK, `cooking`=1 and `mag_on`=1 during cycle k to k+1 (zero added latency).
- `mag_on` is high for P*`SLOT` cycles, then low for F-P*`SLOT` cycles, repeating.
- A door opening drops `mag_on` within the same cycle (combinational). The state reaches PAUSED at the next edge.
- Exiting COOK freezes `ph`. Resume restarts the duty frame at `ph`=0, with `mag_on` high.
- DONE lasts exactly `DONE_CYCLES` cycles, then IDLE, if not cleared earlier.
- Reset asserted mid-COOK forces IDLE and `mag_on`=0 asynchronously.

## Test plan
All scenarios use default parameters (F = 40).

1. **Reset and idle start.** Reset, then `power`=3 and an `Nstart` pulse with door closed -> COOK. `mag_on` is high 12 cycles, low 28 cycles, repeating. Then `time_over`=1 -> DONE for 8 cycles -> IDLE, with `mag_on`=0 throughout DONE.
2. **Door open mid-cook.** `power`=10, start, `door_clo`=0 at cycle 5 -> `mag_on`=0 in that same cycle, PAUSED next edge. Then `door_clo`=1 plus an `Nstart` pulse -> COOK, `ph`=0, `mag_on`=1.
3. **Stop and clear.** Stop during COOK -> PAUSED. A second `Nstop` -> IDLE. Start again, then `Nclear`=0 during COOK -> IDLE directly.
4. **Rejected and held starts.** Start with `door_clo`=0 -> stays IDLE. Start with `time_over`=1 -> stays IDLE. `Nstart` held low for 20 cycles -> a single start event, no re-trigger after a stop.
5. **Simultaneous events and clamping.** In COOK, `time_over`=1 with `door_clo`=0 -> DONE. `time_over`=1 with `Nclear`=0 -> IDLE. `power`=0 -> duty 4/40; `power`=15 -> duty 40/40.
6. **Async reset mid-cook.** `Nreset`=0 pulse mid-COOK, between clock edges -> all outputs 0 immediately, state IDLE after release.
